// File: rtl/sram_responder_if.sv
// sram_responder_if: SRAM-style data port between the core (master) and the
// data-side responder (slave). Read data returns one cycle after the request.
interface sram_responder_if;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (
    output sram_en,
    output sram_wen,
    output sram_addr,
    output sram_wdata,
    input  sram_rdata
  );

  modport slave (
    input  sram_en,
    input  sram_wen,
    input  sram_addr,
    input  sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: data-side responder for the core's SRAM-style port.
// Serves a word-organised RAM with byte enables plus a register window
// (LED, and optionally TIMER/CMP/STATUS with a compare interrupt).
// Read data is registered, giving a fixed one-cycle read latency; every
// request returns the pre-write contents of the addressed location.
// Optional feature macro: SRAM_RSP_TIMER_EN (timer, compare and timer_irq).
module sram_responder #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
  input  logic                    clk,
  input  logic                    resetn,
  sram_responder_if.slave         bus,
  output logic [15:0]             led,
  output logic                    timer_irq
);

  localparam int RAM_WORDS = 1 << ADDR_W;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_LED,
    SEL_TIMER,
    SEL_CMP,
    SEL_STATUS,
    SEL_NONE
  } sel_e;

  sel_e              sel;
  logic [ADDR_W-1:0] word_idx;
  logic              is_mmio;
  logic              ram_we;
  logic              reg_we;
  logic [31:0]       rd_value;
  logic [15:0]       led_next;

  logic [31:0] mem [RAM_WORDS];

  // Merge write data into an existing word, lane by lane.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

  assign is_mmio  = (bus.sram_addr[31:16] == MMIO_BASE[31:16]);
  assign word_idx = bus.sram_addr[ADDR_W+1:2];
  assign ram_we   = bus.sram_en && (sel == SEL_RAM) && (bus.sram_wen != 4'h0);
  assign reg_we   = bus.sram_en && is_mmio && (bus.sram_wen != 4'h0);

  // Address decode: RAM outside the window, register select inside it
  // (byte-offset bits [1:0] are don't-care).
  // NOTE: every variable in an always_comb gets a default before any branch,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    sel = SEL_RAM;
    if (is_mmio) begin
      casez (bus.sram_addr[15:0])
        16'b0000_0000_0000_00??: sel = SEL_LED;
        16'b0000_0000_0000_01??: sel = SEL_TIMER;
        16'b0000_0000_0000_10??: sel = SEL_CMP;
        16'b0000_0000_0000_11??: sel = SEL_STATUS;
        default:                 sel = SEL_NONE;
      endcase
    end
  end

  // RAM byte-lane writes; contents deliberately survive reset.
  // NOTE: the memory array has no reset branch -- resetting it would turn it
  // into thousands of flops and contents must persist across reset anyway.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.sram_wen[i]) mem[word_idx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
      end
    end
  end

  // LED register next value: only lanes 0 and 1 exist.
  assign led_next = {bus.sram_wen[1] ? bus.sram_wdata[15:8] : led[15:8],
                     bus.sram_wen[0] ? bus.sram_wdata[7:0]  : led[7:0]};

  // LED register update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led <= 16'h0000;
    end else if (reg_we && (sel == SEL_LED)) begin
      led <= led_next;
    end
  end

`ifdef SRAM_RSP_TIMER_EN
  logic [31:0] timer_q;
  logic [31:0] cmp_q;
  logic        pending_q;
  logic        timer_hit;
  logic        status_clr;

  // Compare uses the pre-increment timer and the pre-write CMP value.
  assign timer_hit  = (timer_q == cmp_q);
  assign status_clr = reg_we && (sel == SEL_STATUS) && bus.sram_wen[0] && bus.sram_wdata[0];

  // Timer, compare and pending flag; a software TIMER write beats the
  // increment, and a compare-set beats a write-1-clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q   <= 32'h0000_0000;
      cmp_q     <= 32'hffff_ffff;
      pending_q <= 1'b0;
    end else begin
      if (reg_we && (sel == SEL_TIMER)) begin
        timer_q <= merge_lanes(timer_q, bus.sram_wdata, bus.sram_wen);
      end else begin
        timer_q <= timer_q + 32'd1;
      end
      if (reg_we && (sel == SEL_CMP)) begin
        cmp_q <= merge_lanes(cmp_q, bus.sram_wdata, bus.sram_wen);
      end
      if (timer_hit) begin
        pending_q <= 1'b1;
      end else if (status_clr) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign timer_irq = pending_q;
`else
  assign timer_irq = 1'b0;
`endif

  // Read-data selection for the addressed location (pre-write contents).
  always_comb begin
    rd_value = 32'h0000_0000;
    case (sel)
      SEL_RAM:    rd_value = mem[word_idx];
      SEL_LED:    rd_value = {16'h0000, led};
`ifdef SRAM_RSP_TIMER_EN
      SEL_TIMER:  rd_value = timer_q;
      SEL_CMP:    rd_value = cmp_q;
      SEL_STATUS: rd_value = {31'h0, pending_q};
`endif
      default:    rd_value = 32'h0000_0000;
    endcase
  end

  // Registered read data: loads on every request, holds otherwise.
  // NOTE: non-blocking assignment here samples the RAM before this edge's
  // write lands, which is exactly what gives old-data-on-write behaviour.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.sram_rdata <= 32'h0000_0000;
    end else if (bus.sram_en) begin
      bus.sram_rdata <= rd_value;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed self-checking bench for sram_responder.
// Expectations adapt to whether SRAM_RSP_TIMER_EN is defined.
module tb_sram_responder;

  localparam logic [31:0] BASE    = 32'hbfaf_0000;
  localparam logic [31:0] A_LED   = BASE + 32'h0;
  localparam logic [31:0] A_TIMER = BASE + 32'h4;
  localparam logic [31:0] A_CMP   = BASE + 32'h8;
  localparam logic [31:0] A_STAT  = BASE + 32'hc;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] led;
  logic        timer_irq;
  int          checks = 0;
  int          errors = 0;

  sram_responder_if bus ();

  sram_responder #(.ADDR_W(10), .MMIO_BASE(32'hbfaf_0000)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .led       (led),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One request presented for exactly one rising edge; returns 1ns after it.
  task automatic req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.sram_en    = 1'b1;
    bus.sram_wen   = wen;
    bus.sram_addr  = addr;
    bus.sram_wdata = wdata;
    @(posedge clk);
    #1;
    bus.sram_en  = 1'b0;
    bus.sram_wen = 4'h0;
  endtask

  task automatic rd(input logic [31:0] addr);
    req(4'h0, addr, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn         = 1'b0;
    bus.sram_en    = 1'b0;
    bus.sram_wen   = 4'h0;
    bus.sram_addr  = 32'h0;
    bus.sram_wdata = 32'h0;
    #12;
    check("reset_rdata", bus.sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_irq", {31'h0, timer_irq}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Basic RAM write then read
    req(4'hf, 32'h0000_0010, 32'h1234_5678);
    rd(32'h0000_0010);
    check("ram_rd", bus.sram_rdata, 32'h1234_5678);

    // Byte lanes and old-data-on-write
    req(4'hf, 32'h0000_0020, 32'h1111_1111);
    req(4'b0101, 32'h0000_0020, 32'haabb_ccdd);
    rd(32'h0000_0020);
    check("lanes", bus.sram_rdata, 32'h11bb_11dd);
    req(4'hf, 32'h0000_0020, 32'h0000_0000);
    check("old_on_write", bus.sram_rdata, 32'h11bb_11dd);
    rd(32'h0000_0020);
    check("after_full_wr", bus.sram_rdata, 32'h0000_0000);

    // Aliasing above the RAM index range
    req(4'hf, 32'h0000_0000, 32'hdead_beef);
    rd(32'h0000_1000);
    check("alias", bus.sram_rdata, 32'hdead_beef);

    // Idle cycles hold rdata even when the address changes
    bus.sram_addr = 32'h0000_0010;
    idle(2);
    check("hold", bus.sram_rdata, 32'hdead_beef);

    // LED register
    req(4'hf, A_LED, 32'hffff_00a5);
    check("led_pin", {16'h0, led}, 32'h0000_00a5);
    rd(A_LED);
    check("led_rd", bus.sram_rdata, 32'h0000_00a5);
    req(4'b0010, A_LED, 32'h0000_3c00);
    check("led_lane", {16'h0, led}, 32'h0000_3ca5);
    rd(BASE + 32'h20);
    check("mmio_hole", bus.sram_rdata, 32'h0);

`ifdef SRAM_RSP_TIMER_EN
    // Compare interrupt: rises 6 cycles after TIMER=0 write edge when CMP=5
    req(4'hf, A_CMP, 32'd5);
    rd(A_CMP);
    check("cmp_rd", bus.sram_rdata, 32'd5);
    req(4'hf, A_TIMER, 32'd0);
    check("irq_pre", {31'h0, timer_irq}, 32'h0);
    idle(5);
    check("irq_before_match", {31'h0, timer_irq}, 32'h0);
    idle(1);
    check("irq_rise", {31'h0, timer_irq}, 32'h1);
    rd(A_STAT);
    check("status_rd", bus.sram_rdata, 32'h1);
    req(4'h1, A_STAT, 32'h1);
    check("irq_clear", {31'h0, timer_irq}, 32'h0);

    // Clear on the match edge loses to the compare-set
    req(4'hf, A_TIMER, 32'd0);
    idle(5);
    check("irq_low2", {31'h0, timer_irq}, 32'h0);
    req(4'h1, A_STAT, 32'h1);
    check("clear_on_match", {31'h0, timer_irq}, 32'h1);
    req(4'h1, A_STAT, 32'h1);
    check("irq_clear2", {31'h0, timer_irq}, 32'h0);

    // Written TIMER value is the base for the next cycle
    req(4'hf, A_TIMER, 32'd100);
    rd(A_TIMER);
    check("timer_load", bus.sram_rdata, 32'd100);
    rd(A_TIMER);
    check("timer_inc", bus.sram_rdata, 32'd101);
`else
    req(4'hf, A_TIMER, 32'd100);
    rd(A_TIMER);
    check("timer_off", bus.sram_rdata, 32'h0);
    req(4'hf, A_CMP, 32'd5);
    rd(A_CMP);
    check("cmp_off", bus.sram_rdata, 32'h0);
    idle(8);
    check("irq_off", {31'h0, timer_irq}, 32'h0);
`endif

    // Reset while a read is in flight
    rd(32'h0000_0010);
    check("pre_reset_rd", bus.sram_rdata, 32'h1234_5678);
    req(4'hf, A_LED, 32'h0000_0077);
    @(negedge clk);
    bus.sram_en   = 1'b1;
    bus.sram_wen  = 4'h0;
    bus.sram_addr = 32'h0000_0000;
    #2;
    resetn = 1'b0;
    #1;
    check("rst_rdata", bus.sram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    @(posedge clk);
    #1;
    bus.sram_en = 1'b0;
    check("rst_discard", bus.sram_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post_rst_rdata", bus.sram_rdata, 32'h0);
    rd(A_TIMER);
`ifdef SRAM_RSP_TIMER_EN
    check("post_rst_timer", bus.sram_rdata, 32'd1);
`else
    check("post_rst_timer", bus.sram_rdata, 32'd0);
`endif
    rd(32'h0000_0010);
    check("ram_kept_10", bus.sram_rdata, 32'h1234_5678);
    rd(32'h0000_0000);
    check("ram_kept_0", bus.sram_rdata, 32'hdead_beef);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Single-port responder for the CPU's SRAM-style data interface (`en`/`wen`/`addr`/`wdata` out, `rdata` back one cycle later). It sits on the far side of the core's data port, in the SoC wrapper beside the instruction memory. It serves a word-organised RAM with byte write enables and a small memory-mapped register window (LED register, free-running timer with compare interrupt). Read data is always registered, giving the fixed 1-cycle latency that the MEM stage consumes.

## Interface
- `ADDR_W`, 10, RAM word-index width; RAM holds 2^ADDR_W 32-bit words.
- `MMIO_BASE`, 32'hbfaf_0000, base of the register window; match on `addr[31:16] == MMIO_BASE[31:16]`.
- `clk`  in  1  sole clock, rising edge.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `sram_en`  in  1  request valid this cycle.
- `sram_wen`  in  4  byte write enables; 0 = read.
- `sram_addr`  in  32  byte address; bits [1:0] ignored.
- `sram_wdata`  in  32  write data, byte lanes aligned to `sram_wen`.
- `sram_rdata`  out  32  read data, registered.
- `led`  out  16  LED register contents.
- `timer_irq`  out  1  timer compare pending (STATUS bit0).

## Operation
- Decode: MMIO window when the upper half matches; otherwise RAM. RAM word index = `sram_addr[ADDR_W+1:2]`; higher bits are ignored, so the RAM aliases and wraps.
- Every request with `sram_en=1` is both a read and, if `wen!=0`, a write. `sram_rdata` returns the pre-write (old) word for the addressed location. Write lanes update only where `wen[i]=1`.
- `sram_en=0`: no state change from the port; `sram_rdata` holds its last value.
- MMIO offsets (`addr[15:0]`), all byte-enable aware:
  - 0x0 LED: RW; bits [15:0] drive `led`; bits [31:16] read 0.
  - 0x4 TIMER: RW; increments by 1 every cycle and wraps at 2^32; a write loads the written value.
  - 0x8 CMP: RW.
  - 0xC STATUS: bit0 = pending; write 1 to bit0 clears it; other bits read 0.
  - Any other offset reads 0; writes are ignored.
- Compare: when TIMER (pre-increment value) == CMP, STATUS bit0 is set on that edge. `timer_irq` = STATUS bit0.
- Simultaneous events:
  - A software write to TIMER wins over the increment; the next cycle counts from the written value.
  - A compare-set in the same cycle as a write-1-clear leaves the bit set.
  - A compare in the same cycle as a CMP write uses the old CMP.
- Reset (async, any time, including mid-request):
  - `sram_rdata`=0, `led`=0, TIMER=0, CMP=32'hffff_ffff, STATUS=0, `timer_irq`=0.
  - RAM contents are not reset and are preserved across reset.
  - An in-flight read is discarded.

## Timing
- Read latency is exactly 1 cycle: request at edge N, data valid after edge N+1, and it stays stable until the next `en`.
- A write is visible to a read issued the following cycle.
- Back-to-back requests are accepted every cycle with no stall; there is no backpressure.
- `timer_irq` rises the cycle after the match edge and falls the cycle after the clearing write.

## Configuration
- `SRAM_RSP_TIMER_EN` defined: TIMER, CMP, STATUS and `timer_irq` are implemented as above.
- Not defined:
  - Offsets 0x4/0x8/0xC read 0 and ignore writes.
  - `timer_irq` is tied 0 and no counter logic is generated.
  - LED and RAM behaviour are unchanged.

## Test plan
- Reset, then read RAM 0x0000_0010 after writing 32'h1234_5678 with `wen`=4'hf: rdata = 32'h1234_5678 one cycle after the read request; `sram_rdata`/`led`/`timer_irq` are 0 during reset.
- Byte lanes: write 32'haabb_ccdd with `wen`=4'b0101 over 32'h1111_1111. Read returns 32'h11bb_11dd. A write with `wen`=4'hf issued to the same word returns the old 32'h11bb_11dd that cycle.
- Aliasing (ADDR_W=10): write 32'hdead_beef to 0x0000_0000; a read of 0x0000_1000 returns 32'hdead_beef.
- MMIO:
  - Write LED with 32'hffff_00a5: `led`=16'h00a5 next cycle and reads back 32'h0000_00a5.
  - Offset 0x20 reads 0.
- Timer (macro on):
  - Write CMP=5 and TIMER=0: `timer_irq` rises 6 cycles after the TIMER write edge.
  - Writing STATUS=1 clears it.
  - A clear written on the match cycle leaves it set.
- Reset mid-op: assert `resetn`=0 while a read is pending.
  - `sram_rdata`=0 immediately and TIMER=0.
  - After release, a previously written RAM word still reads its old value.
